// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO issue path: decode op classes, unit MDOp/MTOp
// codes and the scheduler state set.
package md_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MTHI  = 4'd6;
  localparam logic [3:0] OP_MTLO  = 4'd7;
  localparam logic [3:0] OP_MFHI  = 4'd8;
  localparam logic [3:0] OP_MFLO  = 4'd9;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MADD  = 3'b101;

  localparam logic [1:0] MT_NONE  = 2'b00;
  localparam logic [1:0] MT_HI    = 2'b01;
  localparam logic [1:0] MT_LO    = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  function automatic logic is_md(logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_MADD);
  endfunction

  function automatic logic is_mt(logic [3:0] op);
    return (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_mf(logic [3:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

  function automatic logic [2:0] md_enc(logic [3:0] op);
    case (op)
      OP_MULT:  return MD_MULT;
      OP_MULTU: return MD_MULTU;
      OP_DIV:   return MD_DIV;
      OP_DIVU:  return MD_DIVU;
      OP_MADD:  return MD_MADD;
      default:  return MD_NONE;
    endcase
  endfunction

  function automatic logic [1:0] mt_enc(logic [3:0] op);
    case (op)
      OP_MTHI: return MT_HI;
      OP_MTLO: return MT_LO;
      default: return MT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// Decode-side request/stall and unit-side control bundle for md_sched.
interface md_sched_if #(parameter int CNT_W = 32);
  logic             req_valid;
  logic [3:0]       req_op;
  logic             flush;
  logic             md_busy;
  logic             stall;
  logic             md_start;
  logic [2:0]       md_op;
  logic [1:0]       mt_op;
  logic             opnd_le;
  logic             wd_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output req_valid, req_op, flush, md_busy,
    input  stall, md_start, md_op, mt_op, opnd_le, wd_err, stall_cnt
  );

  modport slave (
    input  req_valid, req_op, flush, md_busy,
    output stall, md_start, md_op, mt_op, opnd_le, wd_err, stall_cnt
  );
endinterface

// File: rtl/md_wdog.sv
// Watchdog cycle counter: counts while enabled, clears on clr, flags the
// TIMEOUT-th enabled cycle.
module md_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic term
);
  logic [7:0] cnt;

  assign term = en && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge Clk) begin
    if (Reset || clr)     cnt <= '0;
    else if (en && !term) cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/md_sched.sv
// Issue/stall controller in front of the multiply/divide unit; orders HI/LO
// accesses against in-flight results and watches for a hung unit.
module md_sched
  import md_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic       Clk,
  input logic       Reset,
  md_sched_if.slave bus
);
  state_e           state, state_nxt;
  logic [3:0]       op;
  logic             present, unit_hold, hazard, stall_c;
  logic             accept, acc_md, acc_mt;
  logic             wd_term, wd_fire;
  logic             md_start_q, wd_err_q;
  logic [2:0]       md_op_q;
  logic [1:0]       mt_op_q;
  logic [CNT_W-1:0] cnt_q;

  assign op      = bus.req_op;
  assign present = bus.req_valid && !bus.flush && (is_md(op) || is_mt(op) || is_mf(op));
  assign wd_fire = wd_term && bus.md_busy;

  md_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (state != ST_WAIT),
    .en    (state == ST_WAIT),
    .term  (wd_term)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (acc_md) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      // Result ready: either chain straight into the next op or go idle.
      ST_WAIT:  if (!bus.md_busy) state_nxt = acc_md ? ST_ISSUE : ST_IDLE;
                else if (wd_term) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // md_busy is meaningless during ISSUE, so that cycle always holds the unit.
  always_comb begin
    unit_hold = (state == ST_ISSUE) || ((state == ST_WAIT) && bus.md_busy);
    hazard    = is_mf(op) && (mt_op_q != MT_NONE);
    stall_c   = present && (unit_hold || hazard);
    accept    = present && !stall_c;
    acc_md    = accept && is_md(op);
    acc_mt    = accept && is_mt(op);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      md_start_q <= 1'b0;
      md_op_q    <= MD_NONE;
      mt_op_q    <= MT_NONE;
      wd_err_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      md_start_q <= acc_md;
      md_op_q    <= acc_md ? md_enc(op) : MD_NONE;
      mt_op_q    <= acc_mt ? mt_enc(op) : MT_NONE;
      if (wd_fire) wd_err_q <= 1'b1;
      if (stall_c && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall     = stall_c;
  assign bus.opnd_le   = acc_md || acc_mt;
  assign bus.md_start  = md_start_q;
  assign bus.md_op     = md_op_q;
  assign bus.mt_op     = mt_op_q;
  assign bus.wd_err    = wd_err_q;
  assign bus.stall_cnt = cnt_q;
endmodule
